rtc_calendar: RTL and testbench

- Consumer end of the time-setting interface: accepts the packed BCD time word {MMt,MMu,DDt,DDu,hht,hhu,mmt,mmu} and the set-mode flag.
- Validates each requested time and loads it if valid.
- Runs a free-running BCD month/day/hour/minute/second calendar from a clock-derived 1 Hz tick.
- Drives the display and alarm logic downstream.

---
 rtl/rtc_calendar.sv | 158 +++++++++++++++
 tb/tb_rtc_calendar.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_calendar.sv
// BCD month/day/hour/minute/second calendar with validated time loading.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_calendar #(
  parameter int CLK_HZ = 50000000,
  parameter int PRE_W  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_value,
  input  logic        set_time_mode,
  input  logic [15:0] alarm_time,
  input  logic        alarm_en,
  output logic [39:0] cur_time,
  output logic        tick_1hz,
  output logic        load_ok,
  output logic        load_error,
  output logic        alarm_hit
);

  typedef enum logic {ST_RUN, ST_CHECK} state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  function automatic logic [7:0] f_dim(input logic [7:0] month);
    case (month)
      8'h02:                      return 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'h1};
  endfunction

  // BCD ordering matches hex ordering once every nibble is <= 9.
  function automatic logic f_valid(input logic [31:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (c[4*i +: 4] > 4'h9) ok = 1'b0;
    if (c[31:24] < 8'h01 || c[31:24] > 8'h12) ok = 1'b0;
    if (c[23:16] < 8'h01 || c[23:16] > f_dim(c[31:24])) ok = 1'b0;
    if (c[15:8] > 8'h23) ok = 1'b0;
    if (c[7:0]  > 8'h59) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [39:0] f_advance(input logic [39:0] t);
    logic [7:0] mo, dd, hh, mi, ss;
    {mo, dd, hh, mi, ss} = t;
    if (ss != 8'h59) ss = f_bcd_inc(ss);
    else begin
      ss = 8'h00;
      if (mi != 8'h59) mi = f_bcd_inc(mi);
      else begin
        mi = 8'h00;
        if (hh != 8'h23) hh = f_bcd_inc(hh);
        else begin
          hh = 8'h00;
          if (dd != f_dim(mo)) dd = f_bcd_inc(dd);
          else begin
            dd = 8'h01;
            mo = (mo == 8'h12) ? 8'h01 : f_bcd_inc(mo);
          end
        end
      end
    end
    return {mo, dd, hh, mi, ss};
  endfunction

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [31:0]      r_shadow;
  logic [31:0]      r_cand;
  logic [39:0]      r_time;
  logic             r_tick;
  logic             r_ok;
  logic             r_err;

  logic             w_detect;
  logic             w_tick_now;
  logic [39:0]      w_next;

  assign w_detect   = set_time_mode && (time_value != r_shadow);
  assign w_tick_now = (r_state == ST_RUN) && !w_detect && (r_pre == PRE_MAX);
  assign w_next     = f_advance(r_time);

  // NOTE: state and pulse registers use non-blocking assignments so every
  // register samples the pre-edge values, avoiding order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_pre    <= '0;
      r_shadow <= 32'h0;
      r_cand   <= 32'h0;
      r_time   <= 40'h0101000000;
      r_tick   <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          // A load request wins over a coincident tick; the prescaler holds.
          if (w_detect) begin
            r_cand   <= time_value;
            r_shadow <= time_value;
            r_state  <= ST_CHECK;
          end else if (w_tick_now) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
            r_time <= w_next;
          end else begin
            r_pre <= r_pre + PRE_W'(1);
          end
        end
        ST_CHECK: begin
          if (f_valid(r_cand)) begin
            r_time <= {r_cand, 8'h00};
            r_pre  <= '0;
            r_ok   <= 1'b1;
          end else begin
            r_err  <= 1'b1;
          end
          r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign cur_time   = r_time;
  assign tick_1hz   = r_tick;
  assign load_ok    = r_ok;
  assign load_error = r_err;

`ifdef RTC_ALARM_EN
  logic r_alarm;

  // Only the seconds tick can fire the alarm, never a committed load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_alarm <= 1'b0;
    else     r_alarm <= w_tick_now && alarm_en &&
                        (w_next[23:0] == {alarm_time, 8'h00});
  end

  assign alarm_hit = r_alarm;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{alarm_time, alarm_en};
  assign alarm_hit      = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_calendar.sv
// Self-checking bench for rtc_calendar: integer calendar model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_rtc_calendar;

  localparam int CLK_HZ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] time_value = 32'h0;
  logic        set_time_mode = 1'b0;
  logic [15:0] alarm_time = 16'h0;
  logic        alarm_en = 1'b0;
  logic [39:0] cur_time;
  logic        tick_1hz, load_ok, load_error, alarm_hit;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_calendar #(.CLK_HZ(CLK_HZ), .PRE_W(3)) dut (
    .clk(clk), .rst(rst), .time_value(time_value), .set_time_mode(set_time_mode),
    .alarm_time(alarm_time), .alarm_en(alarm_en), .cur_time(cur_time),
    .tick_1hz(tick_1hz), .load_ok(load_ok), .load_error(load_error),
    .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (plain integers) ----------------
  int dim_tab [1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
  int m_mo, m_dd, m_hh, m_mi, m_ss, m_pre;
  logic [31:0] m_shadow, m_cand;
  bit m_pending, m_tick, m_ok, m_err, m_alarm;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int dig2(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit m_valid(input logic [31:0] c);
    int mo, dd, hh, mi;
    for (int i = 0; i < 8; i++)
      if (c[4*i +: 4] > 4'd9) return 1'b0;
    mo = dig2(c[31:24]); dd = dig2(c[23:16]);
    hh = dig2(c[15:8]);  mi = dig2(c[7:0]);
    if (mo < 1 || mo > 12) return 1'b0;
    if (dd < 1 || dd > dim_tab[mo]) return 1'b0;
    return (hh <= 23) && (mi <= 59);
  endfunction

  function automatic logic [39:0] m_time();
    return {to_bcd(m_mo), to_bcd(m_dd), to_bcd(m_hh), to_bcd(m_mi), to_bcd(m_ss)};
  endfunction

  task automatic m_reset();
    m_mo = 1; m_dd = 1; m_hh = 0; m_mi = 0; m_ss = 0; m_pre = 0;
    m_shadow = 32'h0; m_cand = 32'h0; m_pending = 1'b0;
    m_tick = 1'b0; m_ok = 1'b0; m_err = 1'b0; m_alarm = 1'b0;
  endtask

  task automatic m_step();
    m_tick = 1'b0; m_ok = 1'b0; m_err = 1'b0; m_alarm = 1'b0;
    if (m_pending) begin
      m_pending = 1'b0;
      if (m_valid(m_cand)) begin
        m_mo = dig2(m_cand[31:24]); m_dd = dig2(m_cand[23:16]);
        m_hh = dig2(m_cand[15:8]);  m_mi = dig2(m_cand[7:0]);
        m_ss = 0; m_pre = 0; m_ok = 1'b1;
      end else m_err = 1'b1;
    end else if (set_time_mode && time_value != m_shadow) begin
      m_cand = time_value; m_shadow = time_value; m_pending = 1'b1;
    end else begin
      m_pre++;
      if (m_pre == CLK_HZ) begin
        m_pre = 0; m_tick = 1'b1;
        m_ss++;
        if (m_ss == 60) begin m_ss = 0; m_mi++; end
        if (m_mi == 60) begin m_mi = 0; m_hh++; end
        if (m_hh == 24) begin m_hh = 0; m_dd++; end
        if (m_dd > dim_tab[m_mo]) begin m_dd = 1; m_mo++; end
        if (m_mo == 13) m_mo = 1;
`ifdef RTC_ALARM_EN
        m_alarm = alarm_en && m_ss == 0 &&
                  {to_bcd(m_hh), to_bcd(m_mi)} == alarm_time;
`endif
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("model_cur_time",   cur_time,   m_time());
      check("model_tick_1hz",   40'(tick_1hz),   40'(m_tick));
      check("model_load_ok",    40'(load_ok),    40'(m_ok));
      check("model_load_error", 40'(load_error), 40'(m_err));
      check("model_alarm_hit",  40'(alarm_hit),  40'(m_alarm));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_load(input logic [31:0] tv, output logic ok, output logic err);
    @(negedge clk);
    time_value = tv;
    set_time_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ok = load_ok; err = load_error;
  endtask

  task automatic wait_ticks(input int n, output int alarms, output logic [39:0] at_alarm);
    int cnt = 0;
    int budget = n * CLK_HZ + 20;
    alarms = 0; at_alarm = 40'h0;
    while (cnt < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
      if (tick_1hz) cnt++;
      if (alarm_hit) begin alarms++; at_alarm = cur_time; end
    end
    check("ticks_seen", 40'(cnt), 40'(n));
  endtask

  initial begin
    logic ok, err;
    int alarms, n_ok, n_err;
    logic [39:0] at_alarm;

    // 1: reset state and first ticks
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cur_time", cur_time, 40'h0101000000);
    check("rst_pulses", 40'({tick_1hz, load_ok, load_error, alarm_hit}), 40'h0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_tick_low", 40'(tick_1hz), 40'h0);
    @(posedge clk);
    #1;
    check("tick1_pulse", 40'(tick_1hz), 40'h1);
    check("tick1_time", cur_time, 40'h0101000001);
    repeat (3) @(posedge clk);
    #1;
    check("tick2_gap", 40'(tick_1hz), 40'h0);
    @(posedge clk);
    #1;
    check("tick2_time", cur_time, 40'h0101000002);

    // 2: year rollover
    do_load(32'h12312359, ok, err);
    check("t2_ok", 40'({ok, err}), 40'h2);
    check("t2_time", cur_time, 40'h1231235900);
    wait_ticks(60, alarms, at_alarm);
    check("t2_rollover", cur_time, 40'h0101000000);

    // 3: held invalid word produces exactly one error
    @(negedge clk);
    time_value = 32'h02300000;
    n_ok = 0; n_err = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      n_ok  += int'(load_ok);
      n_err += int'(load_error);
    end
    check("t3_err_count", 40'(n_err), 40'd1);
    check("t3_ok_count", 40'(n_ok), 40'd0);
    check("t3_date_kept", 40'(cur_time[39:16]), 40'h010100);

    // 4: month-end carries
    do_load(32'h02282359, ok, err);
    check("t4_feb_ok", 40'(ok), 40'h1);
    wait_ticks(60, alarms, at_alarm);
    check("t4_feb_roll", cur_time, 40'h0301000000);
    do_load(32'h04302359, ok, err);
    check("t4_apr_ok", 40'(ok), 40'h1);
    wait_ticks(60, alarms, at_alarm);
    check("t4_apr_roll", cur_time, 40'h0501000000);

    // 5: invalid loads and loads blocked by set_time_mode=0
    do_load(32'h0A010000, ok, err);
    check("t5_bad_nibble", 40'({ok, err}), 40'h1);
    do_load(32'h01012400, ok, err);
    check("t5_bad_hour", 40'({ok, err}), 40'h1);
    do_load(32'h00010000, ok, err);
    check("t5_bad_month", 40'({ok, err}), 40'h1);
    check("t5_date_kept", 40'(cur_time[39:16]), 40'h050100);
    @(negedge clk);
    set_time_mode = 1'b0;
    time_value = 32'h06150930;
    n_ok = 0; n_err = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      n_ok  += int'(load_ok);
      n_err += int'(load_error);
    end
    check("t5_mode_off", 40'(n_ok + n_err), 40'd0);
    @(negedge clk);
    set_time_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_late_load", 40'(load_ok), 40'h1);
    check("t5_late_time", cur_time, 40'h0615093000);

    // 6: alarm
    @(negedge clk);
    alarm_time = 16'h0001;
    alarm_en = 1'b1;
    do_load(32'h01010001, ok, err);
    check("t6_load_on_alarm", 40'({ok, alarm_hit}), 40'h2);
    do_load(32'h01010000, ok, err);
    wait_ticks(60, alarms, at_alarm);
    check("t6_end_time", cur_time, 40'h0101000100);
`ifdef RTC_ALARM_EN
    check("t6_alarm_count", 40'(alarms), 40'd1);
    check("t6_alarm_time", at_alarm, 40'h0101000100);
`else
    check("t6_alarm_count", 40'(alarms), 40'd0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
